// File: rtl/hazard_stall_unit_pkg.sv
// ============================================================================
// hazard_stall_unit_pkg : shared pipeline constants for the hazard/stall logic
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_stall_unit_pkg;

    localparam int REG_W           = 5;
    localparam int PCSRC_W         = 3;
    localparam int MDU_CNT_W       = 6;
    localparam int STALL_CNT_W     = 8;
    localparam int MDU_LAT_DEFAULT = 32;

    localparam logic [PCSRC_W-1:0] PCSRC_JR = 3'b011;

    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // $0 is hardwired to zero, so it can never carry a pending result.
    function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
// hazard_stall_unit_if : pipeline-register snoop inputs and stall controls
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if;
    import hazard_stall_unit_pkg::*;

    logic [REG_W-1:0]   IF_ID_Rs;
    logic [REG_W-1:0]   IF_ID_Rt;
    logic               IF_ID_UsesRt;
    logic [PCSRC_W-1:0] IF_ID_PCSrc;
    logic               IF_ID_MduOp;
    logic               IF_ID_HiLoRd;
    logic               ID_EX_MemRd;
    logic               ID_EX_RegWr;
    logic [REG_W-1:0]   ID_EX_RegFileWr_addr;
    logic               EX_MEM_MemRd;
    logic [REG_W-1:0]   EX_MEM_RegFileWr_addr;
    logic               EX_BranchTaken;

    logic               PC_Hold;
    logic               IF_ID_Hold;
    logic               ID_EX_Bubble;
    logic               IF_ID_Flush;
    logic               MDU_Start;
    logic               MDU_Busy;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_PCSrc, IF_ID_MduOp,
               IF_ID_HiLoRd, ID_EX_MemRd, ID_EX_RegWr, ID_EX_RegFileWr_addr,
               EX_MEM_MemRd, EX_MEM_RegFileWr_addr, EX_BranchTaken,
        input  PC_Hold, IF_ID_Hold, ID_EX_Bubble, IF_ID_Flush, MDU_Start,
               MDU_Busy
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_PCSrc, IF_ID_MduOp,
               IF_ID_HiLoRd, ID_EX_MemRd, ID_EX_RegWr, ID_EX_RegFileWr_addr,
               EX_MEM_MemRd, EX_MEM_RegFileWr_addr, EX_BranchTaken,
        output PC_Hold, IF_ID_Hold, ID_EX_Bubble, IF_ID_Flush, MDU_Start,
               MDU_Busy
    );

endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit_mdu_busy_tracker.sv
// ============================================================================
// mdu_busy_tracker : IDLE/BUSY FSM with down-counter tracking MDU occupancy
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_busy_tracker
    import hazard_stall_unit_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_start,
    output logic      o_busy
);

    localparam logic [MDU_CNT_W-1:0] c_LOAD = MDU_CNT_W'(MDU_LAT - 1);

    mdu_state_t           r_state;
    mdu_state_t           w_state_nxt;
    logic [MDU_CNT_W-1:0] r_cnt;
    logic [MDU_CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The final cycle (count 0) still reports busy; the FSM drops to IDLE on that edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MDU_IDLE: begin
                if (i_start) begin
                    w_state_nxt = MDU_BUSY;
                    w_cnt_nxt   = c_LOAD;
                end
            end
            MDU_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = MDU_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = MDU_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy = (r_state == MDU_BUSY);

endmodule

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// hazard_stall_unit : load-use / jr / MDU hazard detection and stall control
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          reset,
    hazard_stall_unit_if.slave bus
);

    logic w_mdu_busy;
    logic w_load_use;
    logic w_jr_haz;
    logic w_mdu_haz;
    logic w_hazard;
    logic w_branch;
    logic w_stall;
    logic w_mdu_start;

    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_load_use = bus.ID_EX_MemRd &&
                        (reg_match(bus.ID_EX_RegFileWr_addr, bus.IF_ID_Rs) ||
                         (bus.IF_ID_UsesRt &&
                          reg_match(bus.ID_EX_RegFileWr_addr, bus.IF_ID_Rt)));

    // jr reads its target in decode, so a load still in EX or MEM must be waited on.
    assign w_jr_haz = (bus.IF_ID_PCSrc == PCSRC_JR) &&
                      ((bus.ID_EX_RegWr && bus.ID_EX_MemRd &&
                        reg_match(bus.ID_EX_RegFileWr_addr, bus.IF_ID_Rs)) ||
                       (bus.EX_MEM_MemRd &&
                        reg_match(bus.EX_MEM_RegFileWr_addr, bus.IF_ID_Rs)));

    assign w_mdu_haz = w_mdu_busy && (bus.IF_ID_MduOp || bus.IF_ID_HiLoRd);

    assign w_hazard    = w_load_use || w_jr_haz || w_mdu_haz;
    assign w_branch    = reset && bus.EX_BranchTaken;
    assign w_stall     = reset && w_hazard && !bus.EX_BranchTaken;
    assign w_mdu_start = reset && bus.IF_ID_MduOp && !w_hazard && !bus.EX_BranchTaken;

    assign bus.PC_Hold      = w_stall;
    assign bus.IF_ID_Hold   = w_stall;
    assign bus.ID_EX_Bubble = w_stall || w_branch;
    assign bus.IF_ID_Flush  = w_branch;
    assign bus.MDU_Start    = w_mdu_start;
    assign bus.MDU_Busy     = w_mdu_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (!w_stall) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt != {STALL_CNT_W{1'b1}}) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    mdu_busy_tracker #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_mdu_start),
        .o_busy  (w_mdu_busy)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// tb_hazard_stall_unit : directed checks on a MDU_LAT=4 and a default instance
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    hazard_stall_unit_if ifa ();
    hazard_stall_unit_if ifb ();

    hazard_stall_unit #(.MDU_LAT(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    hazard_stall_unit                dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    assign ifb.IF_ID_Rs              = ifa.IF_ID_Rs;
    assign ifb.IF_ID_Rt              = ifa.IF_ID_Rt;
    assign ifb.IF_ID_UsesRt          = ifa.IF_ID_UsesRt;
    assign ifb.IF_ID_PCSrc           = ifa.IF_ID_PCSrc;
    assign ifb.IF_ID_MduOp           = ifa.IF_ID_MduOp;
    assign ifb.IF_ID_HiLoRd          = ifa.IF_ID_HiLoRd;
    assign ifb.ID_EX_MemRd           = ifa.ID_EX_MemRd;
    assign ifb.ID_EX_RegWr           = ifa.ID_EX_RegWr;
    assign ifb.ID_EX_RegFileWr_addr  = ifa.ID_EX_RegFileWr_addr;
    assign ifb.EX_MEM_MemRd          = ifa.EX_MEM_MemRd;
    assign ifb.EX_MEM_RegFileWr_addr = ifa.EX_MEM_RegFileWr_addr;
    assign ifb.EX_BranchTaken        = ifa.EX_BranchTaken;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ifa.IF_ID_Rs              = '0;
        ifa.IF_ID_Rt              = '0;
        ifa.IF_ID_UsesRt          = 1'b0;
        ifa.IF_ID_PCSrc           = '0;
        ifa.IF_ID_MduOp           = 1'b0;
        ifa.IF_ID_HiLoRd          = 1'b0;
        ifa.ID_EX_MemRd           = 1'b0;
        ifa.ID_EX_RegWr           = 1'b0;
        ifa.ID_EX_RegFileWr_addr  = '0;
        ifa.EX_MEM_MemRd          = 1'b0;
        ifa.EX_MEM_RegFileWr_addr = '0;
        ifa.EX_BranchTaken        = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        clr();
        // Hazard and mult present while in reset: everything must stay low
        ifa.ID_EX_MemRd = 1'b1; ifa.ID_EX_RegFileWr_addr = 5'd8; ifa.IF_ID_Rs = 5'd8;
        ifa.IF_ID_MduOp = 1'b1; ifa.EX_BranchTaken = 1'b1;
        #2;
        chk("rst_pc_hold", ifa.PC_Hold, 0);
        chk("rst_bubble", ifa.ID_EX_Bubble, 0);
        chk("rst_flush", ifa.IF_ID_Flush, 0);
        chk("rst_mdu_start", ifa.MDU_Start, 0);
        chk("rst_mdu_busy", ifa.MDU_Busy, 0);
        chk("rst_stall_cnt", dut_a.r_stall_cnt, 0);
        nxt(); nxt();
        reset = 1'b1;
        clr();

        // lw $0 then use of $0: no stall
        ifa.ID_EX_MemRd = 1'b1; ifa.ID_EX_RegWr = 1'b1; ifa.ID_EX_RegFileWr_addr = 5'd0;
        ifa.IF_ID_UsesRt = 1'b1;
        smp();
        chk("r0_pc_hold", ifa.PC_Hold, 0);
        chk("r0_bubble", ifa.ID_EX_Bubble, 0);

        // lw $8 ; add using $8 as Rs: exactly one stall cycle
        nxt(); clr();
        ifa.ID_EX_MemRd = 1'b1; ifa.ID_EX_RegWr = 1'b1; ifa.ID_EX_RegFileWr_addr = 5'd8;
        ifa.IF_ID_Rs = 5'd8; ifa.IF_ID_Rt = 5'd3; ifa.IF_ID_UsesRt = 1'b1;
        smp();
        chk("lu_pc_hold", ifa.PC_Hold, 1);
        chk("lu_ifid_hold", ifa.IF_ID_Hold, 1);
        chk("lu_bubble", ifa.ID_EX_Bubble, 1);
        chk("lu_flush", ifa.IF_ID_Flush, 0);
        nxt();
        ifa.ID_EX_MemRd = 1'b0; ifa.ID_EX_RegWr = 1'b0; ifa.ID_EX_RegFileWr_addr = 5'd0;
        ifa.EX_MEM_MemRd = 1'b1; ifa.EX_MEM_RegFileWr_addr = 5'd8;
        smp();
        chk("lu_release_hold", ifa.PC_Hold, 0);
        chk("lu_release_bubble", ifa.ID_EX_Bubble, 0);
        chk("lu_stall_cnt_1", dut_a.r_stall_cnt, 1);
        nxt(); clr();
        smp();
        chk("stall_cnt_cleared", dut_a.r_stall_cnt, 0);

        // Rt match only matters when the instruction reads Rt
        nxt(); clr();
        ifa.ID_EX_MemRd = 1'b1; ifa.ID_EX_RegWr = 1'b1; ifa.ID_EX_RegFileWr_addr = 5'd9;
        ifa.IF_ID_Rs = 5'd1; ifa.IF_ID_Rt = 5'd9; ifa.IF_ID_UsesRt = 1'b0;
        smp();
        chk("rt_unused_hold", ifa.PC_Hold, 0);
        nxt();
        ifa.IF_ID_UsesRt = 1'b1;
        smp();
        chk("rt_used_hold", ifa.PC_Hold, 1);

        // jr $31 behind an ALU write to $31: no stall
        nxt(); clr();
        ifa.ID_EX_RegWr = 1'b1; ifa.ID_EX_RegFileWr_addr = 5'd31;
        ifa.IF_ID_PCSrc = 3'b011; ifa.IF_ID_Rs = 5'd31;
        smp();
        chk("jr_alu_hold", ifa.PC_Hold, 0);

        // lw $31 ; jr $31: two stall cycles, released on the third
        nxt(); clr();
        ifa.ID_EX_MemRd = 1'b1; ifa.ID_EX_RegWr = 1'b1; ifa.ID_EX_RegFileWr_addr = 5'd31;
        ifa.IF_ID_PCSrc = 3'b011; ifa.IF_ID_Rs = 5'd31;
        smp();
        chk("jr_c1_hold", ifa.PC_Hold, 1);
        nxt();
        ifa.ID_EX_MemRd = 1'b0; ifa.ID_EX_RegWr = 1'b0; ifa.ID_EX_RegFileWr_addr = 5'd0;
        ifa.EX_MEM_MemRd = 1'b1; ifa.EX_MEM_RegFileWr_addr = 5'd31;
        smp();
        chk("jr_c2_hold", ifa.PC_Hold, 1);
        chk("jr_c2_bubble", ifa.ID_EX_Bubble, 1);
        nxt();
        ifa.EX_MEM_MemRd = 1'b0; ifa.EX_MEM_RegFileWr_addr = 5'd0;
        smp();
        chk("jr_c3_hold", ifa.PC_Hold, 0);
        chk("jr_stall_cnt_2", dut_a.r_stall_cnt, 2);

        // Load-use and taken branch together: branch wins
        nxt(); clr();
        ifa.ID_EX_MemRd = 1'b1; ifa.ID_EX_RegWr = 1'b1; ifa.ID_EX_RegFileWr_addr = 5'd8;
        ifa.IF_ID_Rs = 5'd8; ifa.IF_ID_MduOp = 1'b1; ifa.EX_BranchTaken = 1'b1;
        smp();
        chk("br_flush", ifa.IF_ID_Flush, 1);
        chk("br_bubble", ifa.ID_EX_Bubble, 1);
        chk("br_pc_hold", ifa.PC_Hold, 0);
        chk("br_ifid_hold", ifa.IF_ID_Hold, 0);
        chk("br_mdu_start", ifa.MDU_Start, 0);

        // mult then mflo with MDU_LAT=4
        nxt(); clr();
        smp();
        chk("mdu_idle_after_branch", ifa.MDU_Busy, 0);
        nxt();
        ifa.IF_ID_MduOp = 1'b1;
        smp();
        chk("mult_start", ifa.MDU_Start, 1);
        chk("mult_no_hold", ifa.PC_Hold, 0);
        nxt();
        ifa.IF_ID_MduOp = 1'b0; ifa.IF_ID_HiLoRd = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            smp();
            chk($sformatf("mflo_busy_c%0d", i), ifa.MDU_Busy, 1);
            chk($sformatf("mflo_hold_c%0d", i), ifa.PC_Hold, 1);
            chk($sformatf("mflo_nostart_c%0d", i), ifa.MDU_Start, 0);
            nxt();
        end
        smp();
        chk("mflo_c5_busy", ifa.MDU_Busy, 0);
        chk("mflo_c5_hold", ifa.PC_Hold, 0);
        chk("mflo_stall_cnt_4", dut_a.r_stall_cnt, 4);

        // Stall counter saturates at 255
        nxt(); clr();
        ifa.ID_EX_MemRd = 1'b1; ifa.ID_EX_RegFileWr_addr = 5'd5; ifa.IF_ID_Rs = 5'd5;
        repeat (255) nxt();
        chk("sat_255", dut_a.r_stall_cnt, 255);
        repeat (5) nxt();
        chk("sat_hold_255", dut_a.r_stall_cnt, 255);
        clr();
        nxt();
        chk("sat_cleared", dut_a.r_stall_cnt, 0);

        // Reset mid-BUSY on the default-latency instance (counter at 10)
        ifa.IF_ID_MduOp = 1'b1;
        smp();
        chk("b_start", ifb.MDU_Start, 1);
        nxt(); clr();
        repeat (21) nxt();
        chk("b_cnt_10", dut_b.u_mdu.r_cnt, 10);
        chk("b_busy_before_rst", ifb.MDU_Busy, 1);
        #2;
        reset = 1'b0;
        ifa.IF_ID_MduOp = 1'b1;
        #1;
        chk("b_rst_busy", ifb.MDU_Busy, 0);
        chk("b_rst_cnt", dut_b.u_mdu.r_cnt, 0);
        chk("b_rst_start", ifb.MDU_Start, 0);
        chk("b_rst_hold", ifb.PC_Hold, 0);
        nxt();
        smp();
        reset = 1'b1;
        #1;
        chk("b_rel_start", ifb.MDU_Start, 1);
        chk("b_rel_hold", ifb.PC_Hold, 0);
        chk("b_rel_busy", ifb.MDU_Busy, 0);
        nxt(); clr();
        #1;
        chk("b_busy_after_start", ifb.MDU_Busy, 1);
        chk("b_cnt_loaded", dut_b.u_mdu.r_cnt, 31);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter MDU_LAT, default 32, meaning cycles the multiply/divide unit stays busy after an issue (legal range 2..63).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports IF_ID_Rs, IF_ID_Rt  in  5 each  source registers of the decode-stage instruction.
REQ-005 SHALL have port IF_ID_UsesRt  in  1  decode instruction reads Rt.
REQ-006 SHALL have port IF_ID_PCSrc  in  3  decode PC source; 3'b011 = jr/jalr.
REQ-007 SHALL have ports IF_ID_MduOp, IF_ID_HiLoRd  in  1 each  decode is mult/div issue; decode is mfhi/mflo.
REQ-008 SHALL have ports ID_EX_MemRd, ID_EX_RegWr  in  1 each, and ID_EX_RegFileWr_addr  in  5  (already RegDst-resolved).
REQ-009 SHALL have ports EX_MEM_MemRd  in  1 and EX_MEM_RegFileWr_addr  in  5.
REQ-010 SHALL have port EX_BranchTaken  in  1  branch resolved taken in EX.
REQ-011 SHALL have outputs PC_Hold, IF_ID_Hold, ID_EX_Bubble, IF_ID_Flush, MDU_Start  1 each, and MDU_Busy  out  1.

Function
REQ-012 SHALL raise load-use hazard when ID_EX_MemRd=1, ID_EX_RegFileWr_addr!=0, and it equals IF_ID_Rs or (IF_ID_UsesRt and IF_ID_Rt).
REQ-013 SHALL raise jr hazard when IF_ID_PCSrc=3'b011 and IF_ID_Rs!=0 matches either ID_EX_RegFileWr_addr with ID_EX_RegWr=1 and ID_EX_MemRd=1, or EX_MEM_RegFileWr_addr with EX_MEM_MemRd=1.
REQ-014 SHALL raise MDU hazard when MDU_Busy=1 and (IF_ID_MduOp or IF_ID_HiLoRd).
REQ-015 Any hazard SHALL combinationally assert PC_Hold=IF_ID_Hold=ID_EX_Bubble=1 in the same cycle; hazards are re-evaluated every cycle (no fixed stall length).
REQ-016 EX_BranchTaken=1 SHALL assert IF_ID_Flush=1 and ID_EX_Bubble=1, force PC_Hold=IF_ID_Hold=0, and suppress MDU_Start, overriding any hazard.
REQ-017 MDU_Start SHALL be 1 for exactly one cycle when IF_ID_MduOp=1, no hazard, no EX_BranchTaken.
REQ-018 MDU FSM SHALL have states IDLE and BUSY; IDLE->BUSY on MDU_Start loading a 6-bit down-counter with MDU_LAT-1; BUSY decrements each cycle; BUSY->IDLE when counter==0 at the edge.
REQ-019 MDU_Busy SHALL equal (state==BUSY), registered; a mult/div or mfhi/mflo in decode on the cycle counter reaches 0 still stalls that cycle and proceeds next cycle.
REQ-020 SHALL count consecutive stall cycles in an 8-bit saturating register Stall_Cnt (internal, observable in simulation), cleared on any non-stall cycle; saturates at 255, no wrap.
REQ-021 Register 0 SHALL never cause a hazard.

Reset
REQ-022 reset=0 SHALL immediately force state IDLE, counter 0, Stall_Cnt 0, MDU_Busy 0, independent of clk.
REQ-023 During reset all combinational outputs SHALL be 0; reset mid-BUSY SHALL abandon the operation with no MDU_Start on release.
REQ-024 First edge after reset release SHALL behave as IDLE with no pending hazard history.

Structure
REQ-025 PCSrc encoding (3'b011 JR), MDU_LAT default, and state encodings SHALL live in the shared pipeline constants package.
REQ-026 MDU busy tracker (FSM + down-counter) SHALL be one sub-module, mdu_busy_tracker; hazard compare logic stays in the top.

Verification
REQ-027 lw $8 in ID_EX, add using $8 as Rs in IF_ID -> exactly 1 cycle PC_Hold/IF_ID_Hold/ID_EX_Bubble=1, then 0.
REQ-028 lw $31 followed by jr $31 -> stalls 2 cycles (ID_EX load, then EX_MEM load), third cycle no hold.
REQ-029 mult issued, mflo next with MDU_LAT=4 -> MDU_Start 1 cycle, MDU_Busy 4 cycles, mflo held 4 cycles, released 5th.
REQ-030 Load-use hazard and EX_BranchTaken same cycle -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Hold=0.
REQ-031 lw $0 then use $0 -> no stall.
REQ-032 reset asserted mid-BUSY (counter 10) -> MDU_Busy=0 immediately; after release mult in decode gives MDU_Start with no stall.
